// File: rtl/impulse_detector_pkg.sv
// Shared types and sizing for the impulse detector slice.
// Build with IMPULSE_TIMEOUT_EN defined to add the trigger-timeout output.
package impulse_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_LOW = 2'd0,
      ST_ARMED    = 2'd1,
      ST_TRACK    = 2'd2,
      ST_HOLDOFF  = 2'd3
   } state_t;

   localparam int COS_W          = 16;
   localparam int NUM_COMPONENTS = 12;
   localparam int CNT_W_DEFAULT  = 16;

   // Full-precision width of a sum of n signed COS_W-bit cosines.
   function automatic int sum_width(input int n);
      return COS_W + $clog2(n);
   endfunction

endpackage

// File: rtl/impulse_detector_if.sv
// Sample/threshold inputs and impulse report outputs of the impulse detector.
// o_timeout exists only when IMPULSE_TIMEOUT_EN is defined.
interface impulse_detector_if #(
   parameter int SW    = 18,
   parameter int CNT_W = 16
);
   logic signed [SW-1:0]    i_signal;
   logic                    i_valid;
   logic signed [SW-1:0]    i_threshold;
   logic                    o_event;
   logic signed [SW-1:0]    o_peak;
   logic        [CNT_W-1:0] o_peak_idx;
   logic        [CNT_W-1:0] o_period;
   logic                    o_locked;
`ifdef IMPULSE_TIMEOUT_EN
   logic                    o_timeout;

   modport master (
      output i_signal, i_valid, i_threshold,
      input  o_event, o_peak, o_peak_idx, o_period, o_locked, o_timeout
   );
   modport slave (
      input  i_signal, i_valid, i_threshold,
      output o_event, o_peak, o_peak_idx, o_period, o_locked, o_timeout
   );
`else
   modport master (
      output i_signal, i_valid, i_threshold,
      input  o_event, o_peak, o_peak_idx, o_period, o_locked
   );
   modport slave (
      input  i_signal, i_valid, i_threshold,
      output o_event, o_peak, o_peak_idx, o_period, o_locked
   );
`endif
endinterface

// File: rtl/impulse_detector_sat_counter.sv
// Up-counter with enable and synchronous load that sticks at all-ones.
// Load wins over enable so a restart on the same sample is never lost.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (en && (q != '1)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/impulse_detector.sv
// Threshold-crossing impulse detector: peak, peak offset, trigger period and lock.
// Optional IMPULSE_TIMEOUT_EN adds o_timeout after TIMEOUT quiet samples in ARMED.
module impulse_detector
   import impulse_pkg::*;
#(
   parameter int SW      = 18,
   parameter int CNT_W   = CNT_W_DEFAULT,
   parameter int HOLDOFF = 4,
   parameter int TIMEOUT = 4096
) (
   input logic               clk,
   input logic               rst,
   impulse_detector_if.slave bus
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

   if (HOLDOFF < 1 || TIMEOUT < 1) begin : g_bad_cfg
      $error("impulse_detector: HOLDOFF and TIMEOUT must both be at least 1");
   end

   state_t                  state;
   logic signed [SW-1:0]    sample;
   logic signed [SW-1:0]    thr;
   logic signed [SW-1:0]    peak;
   logic        [CNT_W-1:0] idx;
   logic        [CNT_W-1:0] period_pend;
   logic                    have_prev;
   logic        [CNT_W-1:0] per_cnt;
   logic        [CNT_W-1:0] rel;
   logic        [CNT_W-1:0] rel_inc;
   logic        [CNT_W-1:0] hold_cnt;
   logic                    above;
   logic                    trig;
   logic                    track_hi;
   logic                    track_fall;
   logic                    hold_en;

   assign sample     = bus.i_signal;
   assign thr        = bus.i_threshold;
   assign above      = (sample >= thr);
   assign trig       = bus.i_valid && (state == ST_ARMED) && above;
   assign track_hi   = bus.i_valid && (state == ST_TRACK) && above;
   assign track_fall = bus.i_valid && (state == ST_TRACK) && !above;
   assign hold_en    = bus.i_valid && (state == ST_HOLDOFF);
   assign rel_inc    = (rel == '1) ? rel : rel + CNT_W'(1);

   // Valid samples since the last trigger; the trigger sample itself counts as 1.
   sat_counter #(.W(CNT_W)) u_per_cnt (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.i_valid),
      .load     (trig),
      .load_val (CNT_W'(1)),
      .q        (per_cnt)
   );

   sat_counter #(.W(CNT_W)) u_rel_cnt (
      .clk      (clk),
      .rst      (rst),
      .en       (track_hi),
      .load     (trig),
      .load_val ('0),
      .q        (rel)
   );

   sat_counter #(.W(CNT_W)) u_hold_cnt (
      .clk      (clk),
      .rst      (rst),
      .en       (hold_en),
      .load     (track_fall),
      .load_val ('0),
      .q        (hold_cnt)
   );

`ifdef IMPULSE_TIMEOUT_EN
   logic timeout_hit;
   assign timeout_hit = bus.i_valid && (state == ST_ARMED) && !above &&
                        !bus.o_timeout && (32'(per_cnt) >= TIMEOUT);
`endif

   // Detector FSM and report registers; nothing moves on cycles without i_valid
   // except the one-cycle event pulse, which always drops after one clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_WAIT_LOW;
         peak           <= '0;
         idx            <= '0;
         period_pend    <= '0;
         have_prev      <= 1'b0;
         bus.o_event    <= 1'b0;
         bus.o_peak     <= '0;
         bus.o_peak_idx <= '0;
         bus.o_period   <= '0;
         bus.o_locked   <= 1'b0;
`ifdef IMPULSE_TIMEOUT_EN
         bus.o_timeout  <= 1'b0;
`endif
      end else begin
         bus.o_event <= 1'b0;
         if (bus.i_valid) begin
            unique case (state)
               ST_WAIT_LOW: begin
                  if (!above) begin
                     state <= ST_ARMED;
                  end
               end
               ST_ARMED: begin
                  if (trig) begin
                     state       <= ST_TRACK;
                     peak        <= sample;
                     idx         <= '0;
                     period_pend <= have_prev ? per_cnt : '0;
                     have_prev   <= 1'b1;
`ifdef IMPULSE_TIMEOUT_EN
                     bus.o_timeout <= 1'b0;
                  end else if (timeout_hit) begin
                     bus.o_timeout <= 1'b1;
                     bus.o_locked  <= 1'b0;
                     have_prev     <= 1'b0;
`endif
                  end
               end
               ST_TRACK: begin
                  if (above) begin
                     if (sample > peak) begin
                        peak <= sample;
                        idx  <= rel_inc;
                     end
                  end else begin
                     state          <= ST_HOLDOFF;
                     bus.o_event    <= 1'b1;
                     bus.o_peak     <= peak;
                     bus.o_peak_idx <= idx;
                     bus.o_period   <= period_pend;
                     bus.o_locked   <= (period_pend == bus.o_period) &&
                                       (period_pend != '0) && (bus.o_period != '0);
                  end
               end
               ST_HOLDOFF: begin
                  if (hold_cnt == HOLD_LAST) begin
                     state <= ST_ARMED;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_impulse_detector.sv
// Self-checking bench for impulse_detector (default build, IMPULSE_TIMEOUT_EN undefined).
// Directed scenarios plus randomized traffic, all checked against a queue-based model.
module tb_impulse_detector;
   import impulse_pkg::*;

   localparam int SW      = 18;
   localparam int CNT_W   = 16;
   localparam int HOLDOFF = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   impulse_detector_if #(.SW(SW), .CNT_W(CNT_W)) bus ();

   impulse_detector #(.SW(SW), .CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int  n_checks = 0;
   int  n_bad    = 0;
   int  thr      = 20000;

   // Reference model: a pulse is a list of samples, rearming is a quiet-sample budget.
   bit  m_armed;
   bit  m_in_pulse;
   int  m_quiet;
   int  m_since;
   bit  m_have;
   int  m_cur_period;
   int  pulse_q[$];
   int  e_event, e_peak, e_idx, e_period, e_locked;

   int  seen_periods[$];
   int  seen_locked[$];
   int  seen_peaks[$];
   int  seen_idx[$];

   task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                              input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_armed    = 1'b0;
      m_in_pulse = 1'b0;
      m_quiet    = 0;
      m_since    = 0;
      m_have     = 1'b0;
      m_cur_period = 0;
      pulse_q.delete();
      e_event = 0; e_peak = 0; e_idx = 0; e_period = 0; e_locked = 0;
   endtask

   task automatic modelStep(input int sig, input bit valid);
      bit ge;
      bit trig;
      int best;
      int best_i;
      e_event = 0;
      if (valid) begin
         ge   = (sig >= thr);
         trig = 1'b0;
         if (m_in_pulse) begin
            if (ge) begin
               pulse_q.push_back(sig);
            end else begin
               best   = pulse_q[0];
               best_i = 0;
               foreach (pulse_q[i]) begin
                  if (pulse_q[i] > best) begin
                     best   = pulse_q[i];
                     best_i = i;
                  end
               end
               e_locked   = (m_cur_period != 0 && e_period != 0 && m_cur_period == e_period);
               e_period   = m_cur_period;
               e_peak     = best;
               e_idx      = best_i;
               e_event    = 1;
               m_in_pulse = 1'b0;
               m_armed    = 1'b0;
               m_quiet    = HOLDOFF;
            end
         end else if (m_quiet > 0) begin
            m_quiet--;
            if (m_quiet == 0) m_armed = 1'b1;
         end else if (!m_armed) begin
            if (!ge) m_armed = 1'b1;
         end else if (ge) begin
            trig         = 1'b1;
            m_cur_period = m_have ? m_since : 0;
            m_have       = 1'b1;
            m_in_pulse   = 1'b1;
            pulse_q.delete();
            pulse_q.push_back(sig);
         end
         if (trig) m_since = 1;
         else if (m_since < CNT_MAX) m_since++;
      end
   endtask

   task automatic checkAll(input string pfx);
      checkOutput({pfx, "_event"},  bus.o_event,      e_event);
      checkOutput({pfx, "_peak"},   bus.o_peak,       e_peak);
      checkOutput({pfx, "_idx"},    bus.o_peak_idx,   e_idx);
      checkOutput({pfx, "_period"}, bus.o_period,     e_period);
      checkOutput({pfx, "_locked"}, bus.o_locked,     e_locked);
   endtask

   // One clock: check what the last edge produced, then present the next sample.
   task automatic applyStimulus(input int sig, input bit valid);
      @(negedge clk);
      checkAll("cyc");
      if (bus.o_event) begin
         seen_periods.push_back(int'(bus.o_period));
         seen_locked.push_back(int'(bus.o_locked));
         seen_peaks.push_back(int'(bus.o_peak));
         seen_idx.push_back(int'(bus.o_peak_idx));
      end
      modelStep(sig, valid);
      bus.i_signal    = SW'(sig);
      bus.i_valid     = valid;
      bus.i_threshold = SW'(thr);
   endtask

   task automatic clearSeen();
      seen_periods.delete();
      seen_locked.delete();
      seen_peaks.delete();
      seen_idx.delete();
   endtask

   task automatic doReset();
      @(negedge clk);
      rst         = 1'b1;
      bus.i_valid = 1'b0;
      #1;
      modelReset();
      checkAll("rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clearSeen();
   endtask

   function automatic int trainSample(input int n, input int t0, input int t1,
                                      input int t2, input int t3);
      int shape[4];
      int d;
      shape = '{25000, 30000, 30000, 10000};
      foreach (shape[k]) begin
         d = n - t0; if (d == k) return shape[k];
         d = n - t1; if (d == k) return shape[k];
         d = n - t2; if (d == k) return shape[k];
         d = n - t3; if (d == k) return shape[k];
      end
      return 0;
   endfunction

   initial begin
      int exp_tp[4];
      int exp_tl[4];
      int hold_seq[12];
      int v;
      int sig;
      bit vld;
      exp_tp   = '{0, 100, 100, 95};
      exp_tl   = '{0, 0, 1, 0};
      hold_seq = '{0, 0, 25000, 30000, 10000, 0, 25000, 0, 0, 0, 25000, 10000};

      bus.i_signal    = '0;
      bus.i_valid     = 1'b0;
      bus.i_threshold = SW'(thr);
      modelReset();

      // Idle: long run of zeros produces nothing.
      doReset();
      for (int i = 0; i < 200; i++) applyStimulus(0, 1'b1);
      applyStimulus(0, 1'b1);
      checkOutput("idle_events", seen_periods.size(), 0);

      // Single impulse.
      doReset();
      foreach (hold_seq[i]) if (i < 1) applyStimulus(0, 1'b1);
      applyStimulus(25000, 1'b1);
      applyStimulus(30000, 1'b1);
      applyStimulus(30000, 1'b1);
      applyStimulus(10000, 1'b1);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1);
      checkOutput("single_events", seen_periods.size(), 1);
      checkOutput("single_peak",   seen_peaks.size() > 0 ? seen_peaks[0] : -1, 30000);
      checkOutput("single_idx",    seen_idx.size() > 0 ? seen_idx[0] : -1, 1);
      checkOutput("single_period", seen_periods.size() > 0 ? seen_periods[0] : -1, 0);

      // Periodic train, then a short period that breaks lock.
      doReset();
      for (int n = 0; n < 400; n++) applyStimulus(trainSample(n, 10, 110, 210, 305), 1'b1);
      checkOutput("train_events", seen_periods.size(), 4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("train_period%0d", i),
                     i < seen_periods.size() ? seen_periods[i] : -1, exp_tp[i]);
         checkOutput($sformatf("train_locked%0d", i),
                     i < seen_locked.size() ? seen_locked[i] : -1, exp_tl[i]);
      end

      // Reset in the middle of an impulse, after an earlier event loaded the outputs.
      doReset();
      applyStimulus(0, 1'b1);
      applyStimulus(25000, 1'b1);
      applyStimulus(10000, 1'b1);
      for (int i = 0; i < 6; i++) applyStimulus(0, 1'b1);
      applyStimulus(25000, 1'b1);
      applyStimulus(30000, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      modelReset();
      checkAll("midrst");
      @(negedge clk);
      bus.i_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      clearSeen();
      for (int i = 0; i < 20; i++) applyStimulus(25000, 1'b1);
      checkOutput("midrst_noevent", seen_periods.size(), 0);
      applyStimulus(10000, 1'b1);
      applyStimulus(25000, 1'b1);
      applyStimulus(10000, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1);
      checkOutput("midrst_events", seen_periods.size(), 1);
      checkOutput("midrst_period", seen_periods.size() > 0 ? seen_periods[0] : -1, 0);

      // Half-rate valid: period counts valid samples only; idle cycles carry junk.
      doReset();
      v = 0;
      while (v < 250) begin
         applyStimulus(int'($urandom_range(0, 80000)) - 40000, 1'b0);
         applyStimulus(trainSample(v, 10, 110, 100000, 100000), 1'b1);
         v++;
      end
      checkOutput("halfrate_events", seen_periods.size(), 2);
      checkOutput("halfrate_period", seen_periods.size() > 1 ? seen_periods[1] : -1, 100);

      // Holdoff: crossing 2 samples after the fall is ignored, 6 samples after counts.
      doReset();
      foreach (hold_seq[i]) applyStimulus(hold_seq[i], 1'b1);
      for (int i = 0; i < 6; i++) applyStimulus(0, 1'b1);
      checkOutput("holdoff_events", seen_periods.size(), 2);
      checkOutput("holdoff_period", seen_periods.size() > 1 ? seen_periods[1] : -1, 8);

      // Randomized traffic with a mid-run threshold change.
      doReset();
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) thr = int'($urandom_range(0, 30000)) - 10000;
         sig = int'($urandom_range(0, 60000)) - 20000;
         vld = ($urandom_range(0, 3) != 0);
         applyStimulus(sig, vld);
      end
      applyStimulus(0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
